mul_inverse_divider: RTL

Sequential restoring divider that inverts the project's 6×6→12-bit multiplier datapath. It takes a 2·WIDTH-bit dividend and a WIDTH-bit divisor and produces a 2·WIDTH-bit quotient and a WIDTH-bit remainder. It resolves one quotient bit per clock under a start/busy/done handshake. It sits beside the multiplier so that products can be checked back into their factors, and it serves as the lab's arithmetic-unit exercise.

---
 rtl/mul_inverse_divider.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mul_inverse_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_ZERO_DETECT_EN adds a short path for a zero divisor and drives div_by_zero.
module mul_inverse_divider #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [1:0]           state_dbg
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  // Handshake: start is sampled only in IDLE; busy marks RUN; done is a one-cycle
  // pulse in DONE, and quotient/remainder/div_by_zero stay valid until the next DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic [WIDTH:0]    rem_q;
  logic [DW-1:0]     dvd_q;
  logic [WIDTH-1:0]  dsr_q;

  logic [WIDTH:0]    shifted;
  logic [WIDTH+1:0]  diff;
  logic              fits;
  logic [WIDTH:0]    rem_nx;
  logic [DW-1:0]     dvd_nx;
  logic              zero_fast;

`ifdef DIVIDER_ZERO_DETECT_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // The dividend register doubles as the quotient register: dividend bits leave
  // at the top while quotient bits enter at the bottom.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], dvd_q[DW-1]};
    diff    = {1'b0, shifted} - {2'b00, dsr_q};
    fits    = ~diff[WIDTH+1];
    rem_nx  = fits ? diff[WIDTH:0] : shifted;
    dvd_nx  = {dvd_q[DW-2:0], fits};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = zero_fast ? ZERO : RUN;
      RUN:  if (count == CW'(1)) state_nx = DONE;
      ZERO: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            count <= CW'(DW);
          end
        end
        RUN: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            quotient    <= dvd_nx;
            remainder   <= rem_nx[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        ZERO: begin
          // Same values the full iteration would give for a zero divisor.
          quotient    <= '1;
          remainder   <= dvd_q[WIDTH-1:0];
          div_by_zero <= 1'b1;
          count       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
